// File: rtl/scan_loader.sv
// Byte-to-serial loader for memory_bank's scan chain: shifts each host byte out MSB first,
// capturing the displaced tail bits. Readback path exists only when SCAN_LOADER_READBACK_EN is defined.
module scan_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int SCAN_LEN   = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] byte_in_i,
    input  logic                  byte_valid_i,
    output logic                  byte_ready_o,
    output logic                  scan_enable_o,
    output logic                  scan_out_o,
    input  logic                  scan_in_i,
    output logic [DATA_WIDTH-1:0] readback_byte_o,
    output logic                  readback_valid_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int NUM_BYTES = SCAN_LEN / DATA_WIDTH;
    localparam int BIT_CW    = $clog2(DATA_WIDTH + 1);
    localparam int BYTE_CW   = $clog2(NUM_BYTES + 1);
    localparam logic [BIT_CW-1:0]  BIT_LAST  = BIT_CW'(DATA_WIDTH - 1);
    localparam logic [BYTE_CW-1:0] BYTE_LAST = BYTE_CW'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_BYTE,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BIT_CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [BYTE_CW-1:0]    byte_cnt_q, byte_cnt_d;
    logic                  byte_ready_q, byte_ready_d;
    logic                  scan_enable_q, scan_enable_d;
    logic                  scan_out_q, scan_out_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

`ifdef SCAN_LOADER_READBACK_EN
    logic [DATA_WIDTH-1:0] capture_q, capture_d;
    logic [DATA_WIDTH-1:0] rb_byte_q, rb_byte_d;
    logic                  rb_valid_q, rb_valid_d;
`endif

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        byte_ready_d  = 1'b0;
        scan_enable_d = 1'b0;
        scan_out_d    = 1'b0;
        done_d        = 1'b0;
`ifdef SCAN_LOADER_READBACK_EN
        capture_d     = capture_q;
        rb_byte_d     = rb_byte_q;
        rb_valid_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d      = S_WAIT_BYTE;
                    byte_cnt_d   = '0;
                    byte_ready_d = 1'b1;
                end
            end
            S_WAIT_BYTE: begin
                byte_ready_d = 1'b1;
                if (byte_valid_i && byte_ready_q) begin
                    shift_d       = byte_in_i;
                    bit_cnt_d     = '0;
                    byte_ready_d  = 1'b0;
                    scan_enable_d = 1'b1;
                    scan_out_d    = byte_in_i[DATA_WIDTH-1];
                    state_d       = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Chain shifts on this edge; scan_out is pre-loaded with the next MSB.
                shift_d   = {shift_q[DATA_WIDTH-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + BIT_CW'(1);
`ifdef SCAN_LOADER_READBACK_EN
                capture_d = {capture_q[DATA_WIDTH-2:0], scan_in_i};
`endif
                if (bit_cnt_q == BIT_LAST) begin
                    byte_cnt_d = byte_cnt_q + BYTE_CW'(1);
`ifdef SCAN_LOADER_READBACK_EN
                    rb_byte_d  = {capture_q[DATA_WIDTH-2:0], scan_in_i};
                    rb_valid_d = 1'b1;
`endif
                    if (byte_cnt_q == BYTE_LAST) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d      = S_WAIT_BYTE;
                        byte_ready_d = 1'b1;
                    end
                end else begin
                    scan_enable_d = 1'b1;
                    scan_out_d    = shift_q[DATA_WIDTH-2];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            byte_ready_q  <= 1'b0;
            scan_enable_q <= 1'b0;
            scan_out_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            byte_ready_q  <= byte_ready_d;
            scan_enable_q <= scan_enable_d;
            scan_out_q    <= scan_out_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

`ifdef SCAN_LOADER_READBACK_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            capture_q  <= '0;
            rb_byte_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            capture_q  <= capture_d;
            rb_byte_q  <= rb_byte_d;
            rb_valid_q <= rb_valid_d;
        end
    end

    assign readback_byte_o  = rb_byte_q;
    assign readback_valid_o = rb_valid_q;
`else
    logic unused_scan_in;
    assign unused_scan_in   = scan_in_i;
    assign readback_byte_o  = '0;
    assign readback_valid_o = 1'b0;
`endif

    assign byte_ready_o  = byte_ready_q;
    assign scan_enable_o = scan_enable_q;
    assign scan_out_o    = scan_out_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_scan_loader.sv
// Directed bench for scan_loader against a behavioural 256-bit scan chain;
// readback checks switch on SCAN_LOADER_READBACK_EN.
`timescale 1ns/1ps
module tb_scan_loader;

    logic       clk;
    logic       rst_ni;
    logic       start_i;
    logic [7:0] byte_in_i;
    logic       byte_valid_i;
    logic       byte_ready_o;
    logic       scan_enable_o;
    logic       scan_out_o;
    logic       scan_in_i;
    logic [7:0] readback_byte_o;
    logic       readback_valid_o;
    logic       busy_o;
    logic       done_o;

    int total = 0;
    int bad   = 0;

    `define CHK(tag, obs, exp) begin total++; assert ((obs) === (exp)) else begin bad++; $error("FAIL %s: observed=%0h expected=%0h", tag, (obs), (exp)); end end

    scan_loader dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .start_i          (start_i),
        .byte_in_i        (byte_in_i),
        .byte_valid_i     (byte_valid_i),
        .byte_ready_o     (byte_ready_o),
        .scan_enable_o    (scan_enable_o),
        .scan_out_o       (scan_out_o),
        .scan_in_i        (scan_in_i),
        .readback_byte_o  (readback_byte_o),
        .readback_valid_o (readback_valid_o),
        .busy_o           (busy_o),
        .done_o           (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Chain model: bit 255 is the tail (MSB of the highest address byte).
    logic [255:0] chain = '0;
    assign scan_in_i = chain[255];
    always @(posedge clk) if (scan_enable_o) chain <= {chain[254:0], scan_out_o};

    logic [7:0] rb_seen[$];
    int         done_cnt = 0;
    int         rv_cnt   = 0;
    always @(negedge clk) begin
        if (readback_valid_o) begin
            rb_seen.push_back(readback_byte_o);
            rv_cnt++;
        end
        if (done_o) done_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        int se_cnt = 0;
        byte_in_i    = b;
        byte_valid_i = 1'b1;
        while (!byte_ready_o && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        `CHK("ready_timeout", byte_ready_o, 1'b1)
        @(negedge clk);
        byte_valid_i = 1'b0;
        se_cnt += int'(scan_enable_o);
        repeat (7) begin
            @(negedge clk);
            se_cnt += int'(scan_enable_o);
        end
        @(negedge clk);
        `CHK("se_cycles", se_cnt, 8)
        `CHK("se_off_after", scan_enable_o, 1'b0)
    endtask

    initial begin
        int se_stall;
        int bad_bytes;
        int start_done;
        rst_ni       = 1'b0;
        start_i      = 1'b0;
        byte_in_i    = 8'h00;
        byte_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);

        // Reset state
        `CHK("rst_ready", byte_ready_o, 1'b0)
        `CHK("rst_se", scan_enable_o, 1'b0)
        `CHK("rst_so", scan_out_o, 1'b0)
        `CHK("rst_busy", busy_o, 1'b0)
        `CHK("rst_done", done_o, 1'b0)
        `CHK("rst_rbv", readback_valid_o, 1'b0)
        `CHK("rst_rbb", readback_byte_o, 8'h00)

        // byte_valid in IDLE is ignored
        byte_in_i    = 8'h77;
        byte_valid_i = 1'b1;
        repeat (3) @(negedge clk);
        `CHK("idle_valid_ready", byte_ready_o, 1'b0)
        `CHK("idle_valid_busy", busy_o, 1'b0)
        `CHK("idle_valid_se", scan_enable_o, 1'b0)
        byte_valid_i = 1'b0;

        // Reset during SHIFT
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        `CHK("start_busy", busy_o, 1'b1)
        `CHK("start_ready", byte_ready_o, 1'b1)
        byte_in_i    = 8'hA5;
        byte_valid_i = 1'b1;
        @(negedge clk);
        byte_valid_i = 1'b0;
        `CHK("accept_se", scan_enable_o, 1'b1)
        `CHK("accept_so_msb", scan_out_o, 1'b1)
        `CHK("accept_ready_low", byte_ready_o, 1'b0)
        @(negedge clk);
        `CHK("shift2_so", scan_out_o, 1'b0)
        @(negedge clk);
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        `CHK("midrst_se", scan_enable_o, 1'b0)
        `CHK("midrst_busy", busy_o, 1'b0)
        `CHK("midrst_ready", byte_ready_o, 1'b0)
        repeat (12) @(negedge clk);
        `CHK("midrst_no_done", done_cnt, 0)
        `CHK("midrst_no_rbv", rv_cnt, 0)
        `CHK("midrst_idle_busy", busy_o, 1'b0)

        // Full load 0x1F..0x00 with a stall and a stray start pulse
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            send_byte(8'(i));
            if (i == 20) begin
                `CHK("pre_stall_ready", byte_ready_o, 1'b1)
                se_stall = 0;
                for (int k = 0; k < 10; k++) begin
                    start_i = (k == 4);
                    @(negedge clk);
                    se_stall += int'(scan_enable_o);
                end
                start_i = 1'b0;
                `CHK("stall_se_zero", se_stall, 0)
                `CHK("stall_ready", byte_ready_o, 1'b1)
                `CHK("stall_busy", busy_o, 1'b1)
            end
        end
        `CHK("load1_done", done_o, 1'b1)
        `CHK("load1_done_busy", busy_o, 1'b1)
        `CHK("load1_ready", byte_ready_o, 1'b0)
        @(negedge clk);
        `CHK("load1_done_drop", done_o, 1'b0)
        `CHK("load1_idle_busy", busy_o, 1'b0)
        `CHK("load1_done_cnt", done_cnt, 1)
        bad_bytes = 0;
        for (int a = 0; a < 32; a++) if (chain[a*8 +: 8] !== 8'(a)) bad_bytes++;
        `CHK("load1_image", bad_bytes, 0)
        `CHK("load1_top_byte", chain[255:248], 8'h1F)

        // Back-to-back 0xAA load; readback shows previous image
        rb_seen.delete();
        start_done = done_cnt;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < 32; i++) send_byte(8'hAA);
        `CHK("load2_done", done_o, 1'b1)
        @(negedge clk);
        `CHK("load2_done_cnt", done_cnt - start_done, 1)
        `CHK("load2_idle_busy", busy_o, 1'b0)
        bad_bytes = 0;
        for (int a = 0; a < 32; a++) if (chain[a*8 +: 8] !== 8'hAA) bad_bytes++;
        `CHK("load2_image", bad_bytes, 0)
`ifdef SCAN_LOADER_READBACK_EN
        `CHK("rb_count", rb_seen.size(), 32)
        for (int i = 0; i < rb_seen.size(); i++) begin
            `CHK("rb_byte", rb_seen[i], 8'(31 - i))
        end
`else
        `CHK("rb_none", rv_cnt, 0)
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
